mlaccel_xspi_slave: RTL

Parametrised host-link slave that replaces the fixed quad-only host interface of the accelerator top level. It supports single, dual and quad lane modes, selected per transaction. It has a configurable synchroniser depth and a buffered byte output path (FIFO) with a host-visible ready line. It also reports a sticky framing/drop error. It sits between the SB_IO pad buffers and the command state machine, delivering host bytes on din_* and accepting response bytes on dout_*.

---
 rtl/mlaccel_xspi_slave_if.sv | 20 ++
 rtl/mlaccel_xspi_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_xspi_slave_if.sv
// Byte-level link between the host-link slave and the command state machine:
// host bytes out on din_*, response bytes in on dout_*.
interface mlaccel_xspi_slave_if;
  logic       din_valid;
  logic       din_start;
  logic [7:0] din_data;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] dout_data;

  modport slave (
    output din_valid, din_start, din_data, dout_ready,
    input  dout_valid, dout_data
  );

  modport master (
    input  din_valid, din_start, din_data, dout_ready,
    output dout_valid, dout_data
  );
endinterface

// File: rtl/mlaccel_xspi_slave.sv
// Single/dual/quad host-link slave: synchronised pad sampling, byte receive,
// FIFO-buffered half/full-duplex transmit and a sticky framing/drop error.
module mlaccel_xspi_slave #(
  parameter int SYNC_STAGES = 3,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       spi_csb_di,
  input  logic       spi_clk_di,
  input  logic [3:0] spi_io_di,
  output logic [3:0] spi_io_do,
  output logic [3:0] spi_io_oe,
  output logic       spi_rdy_do,
  output logic       spi_err_do,
  input  logic       err_clear,
  mlaccel_xspi_slave_if.slave host
);
  localparam int PTR_W = $clog2(OFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(OFIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_LATCHED = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_csb_sync, r_clk_sync;
  logic [3:0]             r_io_sync [SYNC_STAGES];
  logic                   r_clk_prev;
  logic                   w_csb_s, w_clk_s, w_rise, w_fall;
  logic [3:0]             w_io_s;

  logic [1:0] r_mode_q, w_mode_next;
  logic [2:0] r_bitcnt, w_bitcnt_next, w_last_bit;
  logic [7:0] r_rx_sh, w_rx_next, w_rx_shifted;
  logic [7:0] r_tx_sh, w_tx_sh_next, w_tx_shifted;
  logic       r_first, w_first_next;
  logic       r_tx_active, w_tx_active_next;
  logic       r_din_valid, w_din_valid_next;
  logic       r_din_start, w_din_start_next;
  logic [7:0] r_din_data, w_din_data_next;
  logic [3:0] r_io_do, r_io_oe, w_io_do_next, w_io_oe_next, w_lane_oe, w_drive;
  logic       r_err, w_err_set, r_rdy, r_dout_ready;
  logic       w_pop, w_push, w_flush;

  logic [7:0]       r_mem [OFIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr, w_wptr_next, w_rptr_next;
  logic [CNT_W-1:0] r_count, w_count_next;

  // csb resets to "selected" so a reset taken mid-transaction stays latched
  // until the real chip select is seen high through the synchroniser.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_csb_sync <= '0;
      r_clk_sync <= '0;
      r_clk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_io_sync[i] <= 4'd0;
    end else begin
      r_csb_sync   <= {r_csb_sync[SYNC_STAGES-2:0], spi_csb_di};
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk_di};
      r_io_sync[0] <= spi_io_di;
      for (int i = 1; i < SYNC_STAGES; i++) r_io_sync[i] <= r_io_sync[i-1];
      r_clk_prev   <= w_clk_s;
    end
  end

  assign w_csb_s = r_csb_sync[SYNC_STAGES-1];
  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_io_s  = r_io_sync[SYNC_STAGES-1];
  assign w_rise  = w_clk_s & ~r_clk_prev;
  assign w_fall  = ~w_clk_s & r_clk_prev;
  assign w_push  = host.dout_valid & r_dout_ready;

  // Lane-width dependent shifts, byte length and output-enable pattern.
  always_comb begin
    w_rx_shifted = {r_rx_sh[3:0], w_io_s};
    w_tx_shifted = {r_tx_sh[3:0], 4'd0};
    w_last_bit   = 3'd1;
    w_lane_oe    = 4'b1111;
    case (r_mode_q)
      2'd0: begin
        w_rx_shifted = {r_rx_sh[6:0], w_io_s[0]};
        w_tx_shifted = {r_tx_sh[6:0], 1'b0};
        w_last_bit   = 3'd7;
        w_lane_oe    = 4'b0010;
      end
      2'd1: begin
        w_rx_shifted = {r_rx_sh[5:0], w_io_s[1:0]};
        w_tx_shifted = {r_tx_sh[5:0], 2'd0};
        w_last_bit   = 3'd3;
        w_lane_oe    = 4'b0011;
      end
      default: begin
        w_rx_shifted = {r_rx_sh[3:0], w_io_s};
        w_tx_shifted = {r_tx_sh[3:0], 4'd0};
        w_last_bit   = 3'd1;
        w_lane_oe    = 4'b1111;
      end
    endcase
  end

  // Transaction FSM with receive/transmit datapath next-state.
  always_comb begin
    w_state_next     = r_state;
    w_mode_next      = r_mode_q;
    w_bitcnt_next    = r_bitcnt;
    w_rx_next        = r_rx_sh;
    w_first_next     = r_first;
    w_tx_sh_next     = r_tx_sh;
    w_tx_active_next = r_tx_active;
    w_din_valid_next = 1'b0;
    w_din_start_next = 1'b0;
    w_din_data_next  = r_din_data;
    w_pop            = 1'b0;
    w_flush          = 1'b0;
    w_err_set        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_csb_s) begin
          w_state_next     = ST_ACTIVE;
          w_mode_next      = mode;
          w_bitcnt_next    = 3'd0;
          w_first_next     = 1'b1;
          w_tx_active_next = 1'b0;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (w_csb_s) begin
          w_state_next     = ST_IDLE;
          w_err_set        = (r_bitcnt != 3'd0) || (r_count != '0) || r_tx_active;
          w_bitcnt_next    = 3'd0;
          w_tx_active_next = 1'b0;
          w_tx_sh_next     = 8'd0;
          w_flush          = 1'b1;
        end else if (w_rise) begin
          w_rx_next = w_rx_shifted;
          if (r_bitcnt == w_last_bit) begin
            w_bitcnt_next = 3'd0;
            // Dual/quad share the lines, so a byte clocked during a tx slot is not data.
            w_din_valid_next = ~(r_tx_active & (r_mode_q != 2'd0));
            w_din_start_next = r_first & w_din_valid_next;
            w_din_data_next  = w_rx_shifted;
            w_first_next     = 1'b0;
          end else begin
            w_bitcnt_next = r_bitcnt + 3'd1;
          end
        end else if (w_fall) begin
          if (r_bitcnt == 3'd0) begin
            if (r_count != '0) begin
              w_pop            = 1'b1;
              w_tx_sh_next     = r_mem[r_rptr];
              w_tx_active_next = 1'b1;
            end else begin
              w_tx_active_next = 1'b0;
            end
          end else if (r_tx_active) begin
            w_tx_sh_next = w_tx_shifted;
          end else begin
            w_tx_sh_next = r_tx_sh;
          end
        end else begin
          w_state_next = ST_ACTIVE;
        end
      end
      ST_LATCHED: begin
        if (w_csb_s) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_LATCHED;
        end
      end
      default: begin
        w_state_next = ST_LATCHED;
      end
    endcase
  end

  // Pad drive values follow the next tx shifter state so they land with it.
  always_comb begin
    case (r_mode_q)
      2'd0:    w_drive = {2'b00, w_tx_sh_next[7], 1'b0};
      2'd1:    w_drive = {2'b00, w_tx_sh_next[7:6]};
      default: w_drive = w_tx_sh_next[7:4];
    endcase
    if (w_tx_active_next) begin
      w_io_do_next = w_drive;
      w_io_oe_next = w_lane_oe;
    end else begin
      w_io_do_next = 4'd0;
      w_io_oe_next = 4'd0;
    end
  end

  // Output FIFO pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    w_wptr_next  = r_wptr;
    w_rptr_next  = r_rptr;
    w_count_next = r_count;
    if (w_flush) begin
      w_wptr_next  = '0;
      w_rptr_next  = '0;
      w_count_next = '0;
    end else begin
      if (w_push) w_wptr_next = r_wptr + PTR_W'(1);
      else        w_wptr_next = r_wptr;
      if (w_pop)  w_rptr_next = r_rptr + PTR_W'(1);
      else        w_rptr_next = r_rptr;
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CNT_W'(1);
        2'b01:   w_count_next = r_count - CNT_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= host.dout_data;
  end

  // Control, status and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_LATCHED;
      r_mode_q     <= 2'd0;
      r_bitcnt     <= 3'd0;
      r_rx_sh      <= 8'd0;
      r_tx_sh      <= 8'd0;
      r_first      <= 1'b0;
      r_tx_active  <= 1'b0;
      r_din_valid  <= 1'b0;
      r_din_start  <= 1'b0;
      r_din_data   <= 8'd0;
      r_io_do      <= 4'd0;
      r_io_oe      <= 4'd0;
      r_err        <= 1'b0;
      r_rdy        <= 1'b0;
      r_dout_ready <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mode_q     <= w_mode_next;
      r_bitcnt     <= w_bitcnt_next;
      r_rx_sh      <= w_rx_next;
      r_tx_sh      <= w_tx_sh_next;
      r_first      <= w_first_next;
      r_tx_active  <= w_tx_active_next;
      r_din_valid  <= w_din_valid_next;
      r_din_start  <= w_din_start_next;
      r_din_data   <= w_din_data_next;
      r_io_do      <= w_io_do_next;
      r_io_oe      <= w_io_oe_next;
      r_err        <= w_err_set | (r_err & ~err_clear);
      r_rdy        <= (w_count_next != '0);
      r_dout_ready <= (w_count_next != FULL_COUNT);
      r_wptr       <= w_wptr_next;
      r_rptr       <= w_rptr_next;
      r_count      <= w_count_next;
    end
  end

  assign host.din_valid  = r_din_valid;
  assign host.din_start  = r_din_start;
  assign host.din_data   = r_din_data;
  assign host.dout_ready = r_dout_ready;
  assign spi_io_do       = r_io_do;
  assign spi_io_oe       = r_io_oe;
  assign spi_rdy_do      = r_rdy;
  assign spi_err_do      = r_err;
endmodule
